// File: rtl/logic_unit_arbiter_if.sv
// Handshake bundle for the two-requester logic unit arbiter.
// master = requesters/consumer side, slave = arbiter side.
interface logic_unit_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_op;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_id;
  logic [15:0]      op_count;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id, op_count
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id, op_count
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Two requesters share one bitwise logic datapath, round-robin arbitrated,
// with a single registered result slot (EMPTY/FULL).
module logic_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  logic_unit_arbiter_if.slave bus
);
  typedef enum logic {
    EMPTY,
    FULL
  } state_e;

  state_e           state_q;
  logic             last_grant_q;
  logic             res_id_q;
  logic [WIDTH-1:0] res_data_q;
  logic [15:0]      op_count_q;

  logic             can_accept;
  logic             winner;
  logic             win_valid;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] res_d;

  // Slot frees up when empty or when the consumer drains it this cycle.
  always_comb begin
    can_accept = rst_n &&
      ((state_q == EMPTY) || bus.res_ready);
  end

  always_comb begin
    winner = ~last_grant_q;
    unique case (1'b1)
      (bus.req0_valid && !bus.req1_valid):
        winner = 1'b0;
      (bus.req1_valid && !bus.req0_valid):
        winner = 1'b1;
      default:
        winner = ~last_grant_q;
    endcase
  end

  always_comb begin
    win_valid = winner ? bus.req1_valid
                       : bus.req0_valid;
    accept    = can_accept && win_valid;
    op_a      = winner ? bus.req1_a : bus.req0_a;
    op_b      = winner ? bus.req1_b : bus.req0_b;
    op_sel    = winner ? bus.req1_op : bus.req0_op;
  end

  always_comb begin
    res_d = '0;
    unique case (op_sel)
      2'b00: res_d = op_a & op_b;
      2'b01: res_d = op_a | op_b;
      2'b10: res_d = op_a ^ op_b;
      2'b11: res_d = op_a & ~op_b;
    endcase
  end

  assign bus.req0_ready = can_accept && !winner;
  assign bus.req1_ready = can_accept && winner;
  assign bus.res_valid  = (state_q == FULL);
  assign bus.res_data   = res_data_q;
  assign bus.res_id     = res_id_q;
  assign bus.op_count   = op_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      res_id_q     <= 1'b0;
      res_data_q   <= '0;
      op_count_q   <= '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q <= FULL;
          end
        end
        FULL: begin
          if (!accept && bus.res_ready) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
      if (accept) begin
        res_data_q   <= res_d;
        res_id_q     <= winner;
        last_grant_q <= winner;
        op_count_q   <= op_count_q + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed-vector bench for logic_unit_arbiter.
// Inputs change on negedge; ready sampled 1ns later, results 1ns after posedge.
module tb_logic_unit_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic_unit_arbiter_if #(.WIDTH(32)) bus ();

  logic_unit_arbiter #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic v, input logic [31:0] a,
                      input logic [31:0] b, input logic [1:0] op);
    bus.req0_valid = v;
    bus.req0_a     = a;
    bus.req0_b     = b;
    bus.req0_op    = op;
  endtask

  task automatic drv1(input logic v, input logic [31:0] a,
                      input logic [31:0] b, input logic [1:0] op);
    bus.req1_valid = v;
    bus.req1_a     = a;
    bus.req1_b     = b;
    bus.req1_op    = op;
  endtask

  task automatic rdy(input string tag, input logic r0,
                     input logic r1);
    #1;
    chk({tag, ".r0"}, 32'(bus.req0_ready), 32'(r0));
    chk({tag, ".r1"}, 32'(bus.req1_ready), 32'(r1));
  endtask

  task automatic res(input string tag, input logic v,
                     input logic [31:0] d, input logic id,
                     input logic [15:0] cnt);
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(bus.res_valid), 32'(v));
    if (v) begin
      chk({tag, ".data"}, bus.res_data, d);
      chk({tag, ".id"}, 32'(bus.res_id), 32'(id));
    end
    chk({tag, ".cnt"}, 32'(bus.op_count), 32'(cnt));
  endtask

  initial begin
    logic w;
    drv0(1'b1, 32'h1111_1111, 32'h2222_2222, 2'b01);
    drv1(1'b1, 32'h3333_3333, 32'h4444_4444, 2'b10);
    bus.res_ready = 1'b1;

    // Reset: readys low even with both valid
    @(negedge clk);
    rdy("rst_rdy", 1'b0, 1'b0);
    res("rst", 1'b0, 32'h0, 1'b0, 16'h0);
    chk("rst.data", bus.res_data, 32'h0);
    chk("rst.id", 32'(bus.res_id), 32'h0);

    // First accept in first cycle out of reset
    @(negedge clk);
    rst_n = 1'b1;
    drv0(1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b00);
    drv1(1'b0, 32'h0, 32'h0, 2'b00);
    rdy("first", 1'b1, 1'b0);
    res("first", 1'b1, 32'hF000_F000, 1'b0, 16'd1);

    // Both valid, res_ready=1: alternate 1,0,1,0 (last grant was 0)
    drv0(1'b1, 32'h1234_5678, 32'h0F0F_0F0F, 2'b01);
    drv1(1'b1, 32'hAAAA_5555, 32'hFFFF_0000, 2'b10);
    w = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rdy("rr", !w, w);
      res("rr", 1'b1,
          w ? 32'h5555_5555 : 32'h1F3F_5F7F, w,
          16'(2 + i));
      w = !w;
    end

    // Stall 3 cycles, operands wiggling; nothing accepted
    bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drv0(1'b1, 32'(i), 32'hFFFF_FFFF, 2'b01);
      drv1(1'b1, 32'hFFFF_FFFF, 32'(i), 2'b01);
      rdy("stall", 1'b0, 1'b0);
      res("stall", 1'b1, 32'h1F3F_5F7F, 1'b0, 16'd5);
    end

    // Drain and refill same cycle; req1 wins
    @(negedge clk);
    bus.res_ready = 1'b1;
    drv1(1'b1, 32'h0000_FFFF, 32'h00FF_00FF, 2'b00);
    rdy("refill", 1'b0, 1'b1);
    res("refill", 1'b1, 32'h0000_00FF, 1'b1, 16'd6);

    // req1 alone, A AND NOT B
    @(negedge clk);
    drv0(1'b0, 32'h0, 32'h0, 2'b00);
    drv1(1'b1, 32'hFFFF_FFFF, 32'h0000_FFFF, 2'b11);
    rdy("andn", 1'b0, 1'b1);
    res("andn", 1'b1, 32'hFFFF_0000, 1'b1, 16'd7);

    // Tie after req1 -> req0 wins
    @(negedge clk);
    drv0(1'b1, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 2'b10);
    rdy("tie0", 1'b1, 1'b0);
    res("tie0", 1'b1, 32'h0F0F_0F0F, 1'b0, 16'd8);

    // Nothing valid: drain to EMPTY, then stay
    @(negedge clk);
    drv0(1'b0, 32'h0, 32'h0, 2'b00);
    drv1(1'b0, 32'h0, 32'h0, 2'b00);
    res("drain", 1'b0, 32'h0, 1'b0, 16'd8);
    @(negedge clk);
    bus.res_ready = 1'b0;
    res("idle", 1'b0, 32'h0, 1'b0, 16'd8);

    // Counter wrap: 65527 more accepts reach 0xFFFF
    @(negedge clk);
    bus.res_ready = 1'b1;
    drv0(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
    drv1(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
    repeat (65527) @(posedge clk);
    #1;
    chk("wrap.ffff", 32'(bus.op_count), 32'h0000_FFFF);
    @(posedge clk);
    #1;
    chk("wrap.zero", 32'(bus.op_count), 32'h0);

    // Reset with a result in flight
    @(negedge clk);
    chk("pre_rst.valid", 32'(bus.res_valid), 32'h1);
    rst_n = 1'b0;
    drv0(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 2'b01);
    drv1(1'b1, 32'h1234_5678, 32'h1234_5678, 2'b10);
    rdy("rst2", 1'b0, 1'b0);
    res("rst2", 1'b0, 32'h0, 1'b0, 16'h0);
    chk("rst2.data", bus.res_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy("post_rst", 1'b1, 1'b0);
    res("post_rst", 1'b1, 32'hFFFF_FFFF, 1'b0, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand and result width in bits.
REQ-002 Ports SHALL be: clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 presents an operation.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-007 req0_op  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 A AND NOT B.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op SHALL mirror REQ-004..REQ-007 for requester 1.
REQ-009 res_valid  output  1  result register holds an undelivered result.
REQ-010 res_ready  input  1  consumer takes result this cycle when high with res_valid.
REQ-011 res_data  output  WIDTH  registered bitwise result.
REQ-012 res_id  output  1  requester index that issued res_data.
REQ-013 op_count  output  16  count of accepted operations, wraps 0xFFFF->0x0000.

Function
REQ-014 Block SHALL share one bitwise logic datapath between two requesters, one accepted operation per cycle maximum.
REQ-015 FSM SHALL have states EMPTY (res_valid=0) and FULL (res_valid=1); res_valid SHALL equal (state==FULL).
REQ-016 can_accept SHALL be high when state==EMPTY, or state==FULL and res_ready=1 (drain and refill same cycle).
REQ-017 Arbitration SHALL be round-robin via a 1-bit last_grant register: one valid -> that requester wins; both valid -> requester != last_grant wins.
REQ-018 reqN_ready SHALL be combinational, high only for the winner and only when can_accept=1; loser's ready SHALL be 0; ready SHALL NOT depend on the winner's own valid beyond arbitration.
REQ-019 Accept occurs when winner's valid and ready are both high; at that edge res_data<=op(a,b), res_id<=winner, last_grant<=winner, op_count<=op_count+1, state<=FULL.
REQ-020 Latency SHALL be exactly 1 cycle: result visible on res_data/res_valid the cycle after accept.
REQ-021 FULL with res_ready=1 and no accept SHALL go to EMPTY; FULL with res_ready=0 SHALL hold res_data, res_id, res_valid stable (no overwrite).
REQ-022 EMPTY with no accept SHALL stay EMPTY; res_ready in EMPTY SHALL be ignored.
REQ-023 last_grant and op_count SHALL change only on accept.
REQ-024 Operand/opcode inputs SHALL be sampled only at the accept edge; changes while not accepted SHALL have no effect.

Reset
REQ-025 On rising clk with rst_n=0: state=EMPTY, res_valid=0, res_data=0, res_id=0, op_count=0, last_grant=1 (requester 0 wins first tie).
REQ-026 During reset cycles req0_ready and req1_ready SHALL be 0; a result in flight at reset SHALL be discarded.
REQ-027 First accept SHALL be possible in the first cycle with rst_n=1.

Verification
REQ-028 After reset, req0_valid=1, a=0xF0F0F0F0, b=0xFF00FF00, op=00, res_ready=1 -> req0_ready=1; next cycle res_valid=1, res_data=0xF000F000, res_id=0, op_count=1.
REQ-029 Both valid every cycle, res_ready=1, ops 01/10 -> grants alternate 0,1,0,1; res_id sequence 0,1,0,1; one result per cycle; op_count increments every cycle.
REQ-030 res_valid=1, res_ready=0 for 3 cycles, both requesters valid -> both readys 0, res_data/res_id unchanged; res_ready=1 -> winner accepted same cycle, new result next cycle.
REQ-031 req1 only, op=11, a=0xFFFFFFFF, b=0x0000FFFF -> res_data=0xFFFF0000, res_id=1; then both valid -> req0 wins.
REQ-032 Preload op_count via 65535 accepts -> op_count=0xFFFF; one more accept -> 0x0000.
REQ-033 rst_n=0 while res_valid=1 -> next edge res_valid=0, res_data=0, op_count=0; both valid after release -> req0 wins.
